// File: rtl/seq_multiplier_if.sv
// Handshake bundle for seq_multiplier: operand channel (x, y, sgn) and product channel (o),
// each with its own valid/ready pair, plus a busy status line.
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 sgn;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   o;
  logic                 busy;

  modport master (
    output in_valid, x, y, sgn, out_ready,
    input  in_ready, out_valid, o, busy
  );

  modport slave (
    input  in_valid, x, y, sgn, out_ready,
    output in_ready, out_valid, o, busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier retiring K multiplier bits per cycle, unsigned or
// two's-complement per operation, with valid/ready handshakes on operands and product.
module seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int K     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  mul
);
  localparam int N  = WIDTH / K;
  localparam int SW = $clog2(N + 1);

  generate
    if (WIDTH < 2 || K < 1 || K > WIDTH || (WIDTH % K) != 0) begin : g_bad_params
      $error("seq_multiplier: illegal WIDTH/K combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   o_reg;
  logic [2*WIDTH-1:0]   partial;
  logic [WIDTH-1:0]     y_reg;
  logic [WIDTH-1:0]     x_mag;
  logic [WIDTH-1:0]     y_mag;
  logic [SW-1:0]        step;
  logic                 neg;
  logic                 calc_last;

  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  assign x_mag     = (mul.sgn && mul.x[WIDTH-1]) ? -mul.x : mul.x;
  assign y_mag     = (mul.sgn && mul.y[WIDTH-1]) ? -mul.y : mul.y;
  assign partial   = {{(2*WIDTH-K){1'b0}}, y_reg[K-1:0]} * mcand;
  assign calc_last = (step == SW'(N));
  assign mul.o     = o_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul.in_valid) state_next = CALC;
      CALC:    if (calc_last)    state_next = DONE;
      DONE:    if (mul.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul.in_ready  = 1'b0;
    mul.busy      = 1'b0;
    mul.out_valid = 1'b0;
    case (state)
      IDLE:    mul.in_ready  = 1'b1;
      CALC:    mul.busy      = 1'b1;
      DONE:    mul.out_valid = 1'b1;
      default: ;
    endcase
  end

  // The extra CALC cycle after the last partial product applies the sign to the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      y_reg <= '0;
      step  <= '0;
      neg   <= 1'b0;
      o_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul.in_valid) begin
            mcand <= {{WIDTH{1'b0}}, x_mag};
            y_reg <= y_mag;
            neg   <= mul.sgn & (mul.x[WIDTH-1] ^ mul.y[WIDTH-1]);
            acc   <= '0;
            step  <= '0;
          end
        end
        CALC: begin
          if (calc_last) begin
            o_reg <= neg ? -acc : acc;
          end else begin
            acc   <= acc + partial;
            mcand <= mcand << K;
            y_reg <= y_reg >> K;
            step  <= step + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=8, K=2: products, latency,
// backpressure and mid-operation reset, with hand-computed expected values.
module tb_seq_multiplier;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   lat;

  seq_multiplier_if #(.WIDTH(8)) mul_bus ();

  seq_multiplier #(.WIDTH(8), .K(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mul   (mul_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one operand set at a negedge; inputs are scrambled after acceptance
  // so that any late sampling of x/y/sgn corrupts the product.
  task automatic apply_stimulus(input logic [7:0] xv, input logic [7:0] yv, input logic sv);
    @(negedge clk);
    mul_bus.in_valid = 1'b1;
    mul_bus.x        = xv;
    mul_bus.y        = yv;
    mul_bus.sgn      = sv;
    @(posedge clk);
    #1;
    mul_bus.in_valid = 1'b0;
    mul_bus.x        = ~xv;
    mul_bus.y        = ~yv;
    mul_bus.sgn      = ~sv;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!mul_bus.out_valid && cycles < 40);
    check_output("out_valid_timeout", 64'(mul_bus.out_valid), 64'd1);
  endtask

  task automatic take_result();
    mul_bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    mul_bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                        input logic sv, input logic [15:0] expected);
    int c;
    apply_stimulus(xv, yv, sv);
    wait_result(c);
    check_output(tag, 64'(mul_bus.o), 64'(expected));
    take_result();
  endtask

  initial begin
    errors            = 0;
    checks            = 0;
    rst_n             = 1'b0;
    mul_bus.in_valid  = 1'b0;
    mul_bus.x         = '0;
    mul_bus.y         = '0;
    mul_bus.sgn       = 1'b0;
    mul_bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_in_ready", 64'(mul_bus.in_ready), 64'd1);
    check_output("reset_out_valid", 64'(mul_bus.out_valid), 64'd0);
    check_output("reset_o", 64'(mul_bus.o), 64'd0);
    check_output("reset_busy", 64'(mul_bus.busy), 64'd0);
    rst_n = 1'b1;

    $display("[TB] unsigned 0xFF*0xFF with latency");
    apply_stimulus(8'hFF, 8'hFF, 1'b0);
    check_output("accept_busy", 64'(mul_bus.busy), 64'd1);
    check_output("accept_in_ready", 64'(mul_bus.in_ready), 64'd0);
    wait_result(lat);
    check_output("latency", 64'(lat), 64'd5);
    check_output("ff_x_ff", 64'(mul_bus.o), 64'hFE01);
    check_output("done_in_ready", 64'(mul_bus.in_ready), 64'd0);
    take_result();
    check_output("after_take_out_valid", 64'(mul_bus.out_valid), 64'd0);
    check_output("after_take_in_ready", 64'(mul_bus.in_ready), 64'd1);
    check_output("o_held_in_idle", 64'(mul_bus.o), 64'hFE01);

    $display("[TB] signed and unsigned directed products");
    run_op("s_m128_x_m128", 8'h80, 8'h80, 1'b1, 16'h4000);
    run_op("s_m128_x_127", 8'h80, 8'h7F, 1'b1, 16'hC080);
    run_op("s_m3_x_7", 8'hFD, 8'h07, 1'b1, 16'hFFEB);
    run_op("u_253_x_7", 8'hFD, 8'h07, 1'b0, 16'h06EB);
    run_op("s_5_x_m1", 8'h05, 8'hFF, 1'b1, 16'hFFFB);
    run_op("u_5_x_255", 8'h05, 8'hFF, 1'b0, 16'h04FB);
    run_op("s_0_x_m128", 8'h00, 8'h80, 1'b1, 16'h0000);
    run_op("s_m1_x_m1", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    run_op("u_18_x_52", 8'h12, 8'h34, 1'b0, 16'h03A8);

    $display("[TB] backpressure in DONE");
    apply_stimulus(8'h0A, 8'h0B, 1'b0);
    wait_result(lat);
    mul_bus.in_valid = 1'b1;
    mul_bus.x        = 8'h03;
    mul_bus.y        = 8'h03;
    mul_bus.sgn      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_output("stall_out_valid", 64'(mul_bus.out_valid), 64'd1);
      check_output("stall_o", 64'(mul_bus.o), 64'h006E);
      check_output("stall_in_ready", 64'(mul_bus.in_ready), 64'd0);
    end
    mul_bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    mul_bus.out_ready = 1'b0;
    check_output("release_out_valid", 64'(mul_bus.out_valid), 64'd0);
    check_output("release_in_ready", 64'(mul_bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    mul_bus.in_valid = 1'b0;
    check_output("next_accept_busy", 64'(mul_bus.busy), 64'd1);
    wait_result(lat);
    check_output("next_op_3x3", 64'(mul_bus.o), 64'h0009);
    take_result();

    $display("[TB] reset during CALC");
    apply_stimulus(8'h07, 8'h09, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_output("abort_out_valid", 64'(mul_bus.out_valid), 64'd0);
    check_output("abort_o", 64'(mul_bus.o), 64'd0);
    check_output("abort_in_ready", 64'(mul_bus.in_ready), 64'd1);
    check_output("abort_busy", 64'(mul_bus.busy), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check_output("abort_no_result", 64'(mul_bus.out_valid), 64'd0);
    run_op("after_abort_3x5", 8'h03, 8'h05, 1'b0, 16'h000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
